// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR over a log2(WIDTH)-stage cascade,
// largest shift first, with a valid/ready handshake and a global-advance stall.
module pipe_shifter #(
    parameter int WIDTH     = 32,
    parameter int SHW       = $clog2(WIDTH),
    parameter bit PIPELINED = 1'b1,
    parameter int TAG_W     = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic adv;

    // One cascade stage: shift by 2^k when en is set; reserved modes pass through.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] d,
        input int               k,
        input logic             en,
        input logic [2:0]       mode,
        input logic             sign
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] res;
        int               s;
        ones = '1;
        s    = 1 << k;
        res  = d;
        if (en) begin
            case (mode)
                3'd0:    res = d << s;
                3'd1:    res = d >> s;
                3'd2:    res = (d >> s) | (sign ? ~(ones >> s) : '0);
                3'd3:    res = (d << s) | (d >> (WIDTH - s));
                3'd4:    res = (d >> s) | (d << (WIDTH - s));
                default: res = d;
            endcase
        end
        return res;
    endfunction

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    if (PIPELINED) begin : g_pipe
        logic [SHW-1:0]   valid_reg;
        logic [WIDTH-1:0] data_reg  [SHW];
        logic [SHW-1:0]   shamt_reg [SHW];
        logic [2:0]       mode_reg  [SHW];
        logic             sign_reg  [SHW];
        logic [TAG_W-1:0] tag_reg   [SHW];

        logic             v_in   [SHW];
        logic [WIDTH-1:0] d_in   [SHW];
        logic [SHW-1:0]   sh_in  [SHW];
        logic [2:0]       m_in   [SHW];
        logic             sg_in  [SHW];
        logic [TAG_W-1:0] t_in   [SHW];
        logic [WIDTH-1:0] st_out [SHW];

        // Slot gi applies stage SHW-1-gi to whatever its predecessor holds.
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign v_in[gi]  = in_valid & in_ready;
                assign d_in[gi]  = in_data;
                assign sh_in[gi] = in_shamt;
                assign m_in[gi]  = in_mode;
                assign sg_in[gi] = in_data[WIDTH-1];
                assign t_in[gi]  = in_tag;
            end else begin : g_next
                assign v_in[gi]  = valid_reg[gi-1];
                assign d_in[gi]  = data_reg[gi-1];
                assign sh_in[gi] = shamt_reg[gi-1];
                assign m_in[gi]  = mode_reg[gi-1];
                assign sg_in[gi] = sign_reg[gi-1];
                assign t_in[gi]  = tag_reg[gi-1];
            end
            assign st_out[gi] = shift_stage(d_in[gi], SHW - 1 - gi, sh_in[gi][SHW-1-gi],
                                             m_in[gi], sg_in[gi]);
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_reg <= '0;
                for (int i = 0; i < SHW; i++) begin
                    data_reg[i]  <= '0;
                    shamt_reg[i] <= '0;
                    mode_reg[i]  <= '0;
                    sign_reg[i]  <= 1'b0;
                    tag_reg[i]   <= '0;
                end
            end else if (adv) begin
                for (int i = 0; i < SHW; i++) begin
                    valid_reg[i] <= v_in[i];
                    data_reg[i]  <= st_out[i];
                    shamt_reg[i] <= sh_in[i];
                    mode_reg[i]  <= m_in[i];
                    sign_reg[i]  <= sg_in[i];
                    tag_reg[i]   <= t_in[i];
                end
            end
        end

        assign out_valid = valid_reg[SHW-1];
        assign out_data  = data_reg[SHW-1];
        assign out_tag   = tag_reg[SHW-1];
        assign out_err   = (mode_reg[SHW-1] > 3'd4);
    end else begin : g_flat
        logic [WIDTH-1:0] chain [SHW+1];
        logic             valid_reg;
        logic [WIDTH-1:0] data_reg;
        logic [TAG_W-1:0] tag_reg;
        logic             err_reg;

        assign chain[0] = in_data;
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            assign chain[gi+1] = shift_stage(chain[gi], SHW - 1 - gi, in_shamt[SHW-1-gi],
                                             in_mode, in_data[WIDTH-1]);
        end

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_reg <= 1'b0;
                data_reg  <= '0;
                tag_reg   <= '0;
                err_reg   <= 1'b0;
            end else if (adv) begin
                valid_reg <= in_valid & in_ready;
                data_reg  <= chain[SHW];
                tag_reg   <= in_tag;
                err_reg   <= (in_mode > 3'd4);
            end
        end

        assign out_valid = valid_reg;
        assign out_data  = data_reg;
        assign out_tag   = tag_reg;
        assign out_err   = err_reg;
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter: a 32-bit pipelined instance with an in-order
// scoreboard, plus a 16-bit single-register instance.
module tb_pipe_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0] in_data, out_data;
    logic [4:0]  in_shamt, in_tag, out_tag;
    logic [2:0]  in_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [15:0] b_in_data, b_out_data;
    logic [3:0]  b_in_shamt;
    logic [2:0]  b_in_mode;
    logic [4:0]  b_in_tag, b_out_tag;

    pipe_shifter #(.WIDTH(32), .PIPELINED(1'b1), .TAG_W(5)) dut (
        .clock(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err)
    );

    pipe_shifter #(.WIDTH(16), .PIPELINED(1'b0), .TAG_W(5)) dut16 (
        .clock(clk), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          lat_chk = 1'b1;
    logic [31:0] held_data;
    logic [4:0]  held_tag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(mon_e.data));
                check("out_tag", 64'(out_tag), 64'(mon_e.tag));
                check("out_err", 64'(out_err), 64'(mon_e.err));
                if (lat_chk) check("latency", 64'(cyc - mon_e.cyc), 64'd5);
                $display("[TB] out data=0x%08h tag=%0d err=%0b", out_data, out_tag, out_err);
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] m,
                         input logic [4:0] t, input logic [31:0] want, input logic werr,
                         input bit push);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_mode  = m;
        in_tag   = t;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (push) begin
                    e.data = want;
                    e.tag  = t;
                    e.err  = werr;
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("issue_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        in_tag    = '0;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_shamt  = '0;
        b_in_mode   = '0;
        b_in_tag    = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_out_data", 64'(b_out_data), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_out_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Mode sweep on 0x80000001 by 4
        issue(32'h8000_0001, 5'd4, 3'd0, 5'd1, 32'h0000_0010, 1'b0, 1'b1);
        issue(32'h8000_0001, 5'd4, 3'd1, 5'd2, 32'h0800_0000, 1'b0, 1'b1);
        issue(32'h8000_0001, 5'd4, 3'd2, 5'd3, 32'hF800_0000, 1'b0, 1'b1);
        issue(32'h8000_0001, 5'd4, 3'd3, 5'd4, 32'h0000_0018, 1'b0, 1'b1);
        issue(32'h8000_0001, 5'd4, 3'd4, 5'd5, 32'h1800_0000, 1'b0, 1'b1);
        drain();

        // Back-to-back with a 3-cycle output stall mid-stream
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(32'h1, 5'(i), 3'd0, 5'(i + 8), 32'h1 << i, 1'b0, 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    if (j == 0) begin
                        held_data = out_data;
                        held_tag  = out_tag;
                    end else begin
                        check("stall_data", 64'(out_data), 64'(held_data));
                        check("stall_tag", 64'(out_tag), 64'(held_tag));
                    end
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset mid-operation: nothing in flight may emerge
        issue(32'h0000_0003, 5'd1, 3'd0, 5'd17, 32'h0, 1'b0, 1'b0);
        issue(32'h0000_0005, 5'd2, 3'd0, 5'd18, 32'h0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0007;
        in_shamt = 5'd3;
        in_mode  = 3'd0;
        in_tag   = 5'd19;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        issue(32'h0000_00F0, 5'd4, 3'd1, 5'd21, 32'h0000_000F, 1'b0, 1'b1);
        drain();

        // Edge values
        issue(32'h7FFF_FFFF, 5'd31, 3'd2, 5'd6, 32'h0000_0000, 1'b0, 1'b1);
        issue(32'h0000_0001, 5'd1, 3'd4, 5'd7, 32'h8000_0000, 1'b0, 1'b1);
        issue(32'h8000_1234, 5'd0, 3'd2, 5'd9, 32'h8000_1234, 1'b0, 1'b1);
        issue(32'hDEAD_BEEF, 5'd7, 3'd6, 5'd10, 32'hDEAD_BEEF, 1'b1, 1'b1);
        drain();

        // 16-bit single-register build: result one cycle after issue
        b_in_valid = 1'b1;
        b_in_data  = 16'h8001;
        b_in_shamt = 4'd15;
        b_in_mode  = 3'd2;
        b_in_tag   = 5'd11;
        @(posedge clk); #1;
        check("w16_sra_valid", 64'(b_out_valid), 64'd1);
        check("w16_sra_data", 64'(b_out_data), 64'hFFFF);
        check("w16_sra_tag", 64'(b_out_tag), 64'd11);
        $display("[TB] w16 out data=0x%04h tag=%0d", b_out_data, b_out_tag);
        b_in_mode = 3'd0;
        b_in_tag  = 5'd12;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("w16_sll_valid", 64'(b_out_valid), 64'd1);
        check("w16_sll_data", 64'(b_out_data), 64'h8000);
        check("w16_sll_err", 64'(b_out_err), 64'd0);
        $display("[TB] w16 out data=0x%04h tag=%0d", b_out_data, b_out_tag);
        @(posedge clk); #1;
        check("w16_idle_valid", 64'(b_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
